// File: rtl/cu_mon_pkg.sv
// Shared controller-monitor definitions: opcode/EXE encodings, expected-value
// table, mismatch-mask bit positions and monitor state encoding.
package cu_mon_pkg;

  localparam int OP_CODE_LEN = 6;
  localparam int EXE_CMD_LEN = 4;

  localparam logic [OP_CODE_LEN-1:0] OP_NOP  = 6'b000000;
  localparam logic [OP_CODE_LEN-1:0] OP_ADD  = 6'b000001;
  localparam logic [OP_CODE_LEN-1:0] OP_SUB  = 6'b000011;
  localparam logic [OP_CODE_LEN-1:0] OP_AND  = 6'b000101;
  localparam logic [OP_CODE_LEN-1:0] OP_OR   = 6'b000110;
  localparam logic [OP_CODE_LEN-1:0] OP_NOR  = 6'b000111;
  localparam logic [OP_CODE_LEN-1:0] OP_XOR  = 6'b001000;
  localparam logic [OP_CODE_LEN-1:0] OP_SLA  = 6'b001001;
  localparam logic [OP_CODE_LEN-1:0] OP_SLL  = 6'b001010;
  localparam logic [OP_CODE_LEN-1:0] OP_SRA  = 6'b001011;
  localparam logic [OP_CODE_LEN-1:0] OP_SRL  = 6'b001100;
  localparam logic [OP_CODE_LEN-1:0] OP_ADDI = 6'b100000;
  localparam logic [OP_CODE_LEN-1:0] OP_SUBI = 6'b100001;
  localparam logic [OP_CODE_LEN-1:0] OP_LD   = 6'b100100;
  localparam logic [OP_CODE_LEN-1:0] OP_ST   = 6'b100101;
  localparam logic [OP_CODE_LEN-1:0] OP_BEZ  = 6'b101000;
  localparam logic [OP_CODE_LEN-1:0] OP_BNE  = 6'b101001;
  localparam logic [OP_CODE_LEN-1:0] OP_JMP  = 6'b101010;

  localparam logic [EXE_CMD_LEN-1:0] EXE_ADD          = 4'b0000;
  localparam logic [EXE_CMD_LEN-1:0] EXE_SUB          = 4'b0010;
  localparam logic [EXE_CMD_LEN-1:0] EXE_AND          = 4'b0100;
  localparam logic [EXE_CMD_LEN-1:0] EXE_OR           = 4'b0101;
  localparam logic [EXE_CMD_LEN-1:0] EXE_NOR          = 4'b0110;
  localparam logic [EXE_CMD_LEN-1:0] EXE_XOR          = 4'b0111;
  localparam logic [EXE_CMD_LEN-1:0] EXE_SLA          = 4'b1000;
  localparam logic [EXE_CMD_LEN-1:0] EXE_SLL          = 4'b1000;
  localparam logic [EXE_CMD_LEN-1:0] EXE_SRA          = 4'b1001;
  localparam logic [EXE_CMD_LEN-1:0] EXE_SRL          = 4'b1010;
  localparam logic [EXE_CMD_LEN-1:0] EXE_NO_OPERATION = 4'b1111;

  localparam int MB_EXE  = 4;
  localparam int MB_IMM  = 3;
  localparam int MB_WB   = 2;
  localparam int MB_MEMR = 1;
  localparam int MB_MEMW = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } mon_state_t;

  typedef struct packed {
    logic [EXE_CMD_LEN-1:0] exe;
    logic                   imm;
    logic                   wb;
    logic                   mem_r;
    logic                   mem_w;
    logic                   imm_dc;
    logic                   mem_r_dc;
  } exp_t;

  typedef struct packed {
    logic [OP_CODE_LEN-1:0] op;
    exp_t                   fld;
  } sample_t;

  // Hazard bubbles are checked for every opcode; otherwise only table entries.
  function automatic logic op_checked(input logic [OP_CODE_LEN-1:0] op, input logic hazard);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_SLA, OP_SRA, OP_AND, OP_OR, OP_NOR, OP_XOR,
      OP_SLL, OP_SRL, OP_ADDI, OP_SUBI, OP_LD, OP_ST: ok = 1'b1;
      default:                                        ok = 1'b0;
    endcase
    return ok || hazard;
  endfunction

  function automatic exp_t exp_lookup(input logic [OP_CODE_LEN-1:0] op, input logic hazard);
    exp_t e;
    e     = '0;
    e.exe = EXE_NO_OPERATION;
    if (hazard) begin
      e.imm_dc   = 1'b1;
      e.mem_r_dc = 1'b1;
    end else begin
      e.wb = 1'b1;
      case (op)
        OP_ADD:  e.exe = EXE_ADD;
        OP_SUB:  e.exe = EXE_SUB;
        OP_SLA:  e.exe = EXE_SLA;
        OP_SRA:  e.exe = EXE_SRA;
        OP_AND:  e.exe = EXE_AND;
        OP_OR:   e.exe = EXE_OR;
        OP_NOR:  e.exe = EXE_NOR;
        OP_XOR:  e.exe = EXE_XOR;
        OP_SLL:  e.exe = EXE_SLL;
        OP_SRL:  e.exe = EXE_SRL;
        OP_ADDI: begin e.exe = EXE_ADD; e.imm = 1'b1; end
        OP_SUBI: begin e.exe = EXE_SUB; e.imm = 1'b1; end
        OP_LD:   begin e.exe = EXE_ADD; e.imm = 1'b1; e.mem_r = 1'b1; end
        OP_ST:   begin e.exe = EXE_ADD; e.imm = 1'b1; e.wb = 1'b0; e.mem_w = 1'b1; end
        default: e.wb = 1'b0;
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/cu_mon_pipe.sv
// Fixed-latency delay line for monitor samples: a valid bit plus an opaque
// payload, flushable in one cycle.
module cu_mon_pipe #(
  parameter int LATENCY = 1,
  parameter int W       = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic [LATENCY-1:0] valid_q;
  logic [W-1:0]       data_q [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= valid_i;
      for (int i = 1; i < LATENCY; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // NOTE: payload storage is only ever read when its valid bit is set, so it
  // carries no reset; this keeps it a plain register array.
  always_ff @(posedge clk) begin
    data_q[0] <= data_i;
    for (int i = 1; i < LATENCY; i++) data_q[i] <= data_q[i-1];
  end

  assign valid_o = valid_q[LATENCY-1];
  assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/cu_ctrl_monitor.sv
// Observation-only checker: samples opcode/hazard, and LATENCY cycles later
// compares the live controller outputs against the expected-value table.
module cu_ctrl_monitor
  import cu_mon_pkg::*;
#(
  parameter int LATENCY     = 1,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [OP_CODE_LEN-1:0] opCode,
  input  logic                   hazard_detected,
  input  logic [EXE_CMD_LEN-1:0] EXE_CMD,
  input  logic                   Is_Imm,
  input  logic                   WB_EN,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  output logic                   err,
  output logic [CNT_W-1:0]       err_count,
  output logic [CNT_W-1:0]       chk_count,
  output logic [OP_CODE_LEN-1:0] first_err_op,
  output logic [4:0]             first_err_mask,
  output logic [1:0]             state
);

  mon_state_t             state_q;
  logic                   err_q;
  logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]       chk_cnt_q, chk_cnt_d;
  logic [OP_CODE_LEN-1:0] first_op_q;
  logic [4:0]             first_mask_q, mask_d;

  sample_t smp_in, smp_out;
  logic    smp_in_valid, smp_out_valid;
  logic    do_check, mismatch, halt_entry;

  assign smp_in       = '{op: opCode, fld: exp_lookup(opCode, hazard_detected)};
  assign smp_in_valid = (state_q == ST_RUN) && op_checked(opCode, hazard_detected);

  cu_mon_pipe #(
    .LATENCY (LATENCY),
    .W       ($bits(sample_t))
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .flush_i (clear || halt_entry),
    .valid_i (smp_in_valid),
    .data_i  (smp_in),
    .valid_o (smp_out_valid),
    .data_o  (smp_out)
  );

  // NOTE: combinational blocks use blocking assignments and give every output
  // a default first, so no latch can be inferred.
  always_comb begin
    mask_d          = '0;
    mask_d[MB_EXE]  = (EXE_CMD != smp_out.fld.exe);
    mask_d[MB_IMM]  = !smp_out.fld.imm_dc && (Is_Imm != smp_out.fld.imm);
    mask_d[MB_WB]   = (WB_EN != smp_out.fld.wb);
    mask_d[MB_MEMR] = !smp_out.fld.mem_r_dc && (MEM_R_EN != smp_out.fld.mem_r);
    mask_d[MB_MEMW] = (MEM_W_EN != smp_out.fld.mem_w);
  end

  assign do_check   = smp_out_valid && (state_q != ST_HALT) && !clear;
  assign mismatch   = do_check && (|mask_d);
  assign halt_entry = mismatch && (STOP_ON_ERR != 0) && (state_q == ST_RUN);
  assign chk_cnt_d  = (chk_cnt_q == '1) ? chk_cnt_q : chk_cnt_q + CNT_W'(1);
  assign err_cnt_d  = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
      chk_cnt_q    <= '0;
      first_op_q   <= '0;
      first_mask_q <= '0;
    end else if (clear) begin
      state_q      <= ST_IDLE;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
      chk_cnt_q    <= '0;
      first_op_q   <= '0;
      first_mask_q <= '0;
    end else begin
      if (do_check) chk_cnt_q <= chk_cnt_d;
      if (mismatch) begin
        err_cnt_q <= err_cnt_d;
        err_q     <= 1'b1;
        if (!err_q) begin
          first_op_q   <= smp_out.op;
          first_mask_q <= mask_d;
        end
      end
      // HALT is left only through clear, handled above.
      case (state_q)
        ST_IDLE: if (enable) state_q <= ST_RUN;
        ST_RUN: begin
          if (halt_entry)   state_q <= ST_HALT;
          else if (!enable) state_q <= ST_IDLE;
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign err            = err_q;
  assign err_count      = err_cnt_q;
  assign chk_count      = chk_cnt_q;
  assign first_err_op   = first_op_q;
  assign first_err_mask = first_mask_q;
  assign state          = state_q;

endmodule

// File: tb/tb_cu_ctrl_monitor.sv
// Directed bench for cu_ctrl_monitor: four parameterisations share one stimulus
// stream; expected outputs are queued at drive time and compared on output.
module tb_cu_ctrl_monitor;
  import cu_mon_pkg::*;

  logic                   clk;
  logic                   rst;
  logic                   enable;
  logic                   clear;
  logic [OP_CODE_LEN-1:0] opCode;
  logic                   hazard_detected;
  logic [EXE_CMD_LEN-1:0] EXE_CMD;
  logic                   Is_Imm, WB_EN, MEM_R_EN, MEM_W_EN;

  logic        l1_err, l3_err, st_err, sat_err;
  logic [15:0] l1_errc, l3_errc, st_errc, l1_chk, l3_chk, st_chk;
  logic [1:0]  sat_errc, sat_chk;
  logic [5:0]  l1_op, l3_op, st_op, sat_op;
  logic [4:0]  l1_mask, l3_mask, st_mask, sat_mask;
  logic [1:0]  l1_st, l3_st, st_st, sat_st;

  typedef struct packed {
    logic [1:0]  state;
    logic        err;
    logic [15:0] errc;
    logic [15:0] chkc;
    logic [5:0]  op;
    logic [4:0]  mask;
  } outs_t;

  typedef struct {
    string tag;
    int    dut;
    outs_t v;
  } exp_rec_t;

  localparam int D_L1 = 0, D_L3 = 1, D_ST = 2, D_SAT = 3;

  exp_rec_t sb[$];
  int       n_assert = 0;
  int       n_fail   = 0;

  cu_ctrl_monitor #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .opCode(opCode),
    .hazard_detected(hazard_detected), .EXE_CMD(EXE_CMD), .Is_Imm(Is_Imm),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .err(l1_err), .err_count(l1_errc), .chk_count(l1_chk),
    .first_err_op(l1_op), .first_err_mask(l1_mask), .state(l1_st));

  cu_ctrl_monitor #(.LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .opCode(opCode),
    .hazard_detected(hazard_detected), .EXE_CMD(EXE_CMD), .Is_Imm(Is_Imm),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .err(l3_err), .err_count(l3_errc), .chk_count(l3_chk),
    .first_err_op(l3_op), .first_err_mask(l3_mask), .state(l3_st));

  cu_ctrl_monitor #(.LATENCY(1), .STOP_ON_ERR(1)) u_stop (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .opCode(opCode),
    .hazard_detected(hazard_detected), .EXE_CMD(EXE_CMD), .Is_Imm(Is_Imm),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .err(st_err), .err_count(st_errc), .chk_count(st_chk),
    .first_err_op(st_op), .first_err_mask(st_mask), .state(st_st));

  cu_ctrl_monitor #(.LATENCY(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .opCode(opCode),
    .hazard_detected(hazard_detected), .EXE_CMD(EXE_CMD), .Is_Imm(Is_Imm),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .err(sat_err), .err_count(sat_errc), .chk_count(sat_chk),
    .first_err_op(sat_op), .first_err_mask(sat_mask), .state(sat_st));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t get_obs(input int d);
    outs_t o;
    case (d)
      D_L1:    o = '{l1_st, l1_err, l1_errc, l1_chk, l1_op, l1_mask};
      D_L3:    o = '{l3_st, l3_err, l3_errc, l3_chk, l3_op, l3_mask};
      D_ST:    o = '{st_st, st_err, st_errc, st_chk, st_op, st_mask};
      default: o = '{sat_st, sat_err, {14'd0, sat_errc}, {14'd0, sat_chk}, sat_op, sat_mask};
    endcase
    return o;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int dut, input logic [1:0] st,
                            input logic e, input logic [15:0] errc, input logic [15:0] chk,
                            input logic [5:0] op, input logic [4:0] mask);
    exp_rec_t r;
    r.tag = tag;
    r.dut = dut;
    r.v   = '{st, e, errc, chk, op, mask};
    sb.push_back(r);
  endtask

  task automatic check_out();
    exp_rec_t r;
    outs_t    o;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard: observed empty queue, required a pending entry");
      return;
    end
    r = sb.pop_front();
    o = get_obs(r.dut);
    check({r.tag, ".state"}, 16'(o.state), 16'(r.v.state));
    check({r.tag, ".err"},   16'(o.err),   16'(r.v.err));
    check({r.tag, ".errc"},  o.errc,       r.v.errc);
    check({r.tag, ".chk"},   o.chkc,       r.v.chkc);
    check({r.tag, ".op"},    16'(o.op),    16'(r.v.op));
    check({r.tag, ".mask"},  16'(o.mask),  16'(r.v.mask));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ctrl(input logic [3:0] exe, input logic imm, input logic wb,
                          input logic mr, input logic mw);
    EXE_CMD  = exe;
    Is_Imm   = imm;
    WB_EN    = wb;
    MEM_R_EN = mr;
    MEM_W_EN = mw;
  endtask

  task automatic do_clear();
    clear           = 1'b1;
    enable          = 1'b0;
    opCode          = OP_NOP;
    hazard_detected = 1'b0;
    step();
    clear = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    enable          = 1'b0;
    clear           = 1'b0;
    opCode          = OP_NOP;
    hazard_detected = 1'b0;
    set_ctrl(EXE_ADD, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state of every instance
    #12;
    for (int d = 0; d < 4; d++) begin
      expect_out("reset", d, 2'd0, 1'b0, 16'd0, 16'd0, 6'd0, 5'd0);
      check_out();
    end
    @(negedge clk);
    rst = 1'b0;

    // LATENCY=1: ADD checked one cycle after sampling; LATENCY=3 two cycles later
    enable = 1'b1;
    step();
    opCode = OP_ADD;
    step();
    opCode = OP_NOP;
    set_ctrl(EXE_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("l1_add", D_L1, 2'd1, 1'b0, 16'd0, 16'd1, 6'd0, 5'd0);
    step();
    check_out();
    step();
    expect_out("l3_add", D_L3, 2'd1, 1'b0, 16'd0, 16'd1, 6'd0, 5'd0);
    step();
    check_out();
    do_clear();

    // LATENCY=3: LD with correct outputs at the third cycle, then at the first
    enable = 1'b1;
    step();
    opCode = OP_LD;
    step();
    opCode = OP_NOP;
    set_ctrl(EXE_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    step();
    set_ctrl(EXE_ADD, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_out("l3_ld_ok", D_L3, 2'd1, 1'b0, 16'd0, 16'd1, 6'd0, 5'd0);
    step();
    check_out();
    opCode = OP_LD;
    step();
    opCode = OP_NOP;
    step();
    set_ctrl(EXE_NO_OPERATION, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    expect_out("l3_ld_early", D_L3, 2'd1, 1'b1, 16'd1, 16'd2, OP_LD, 5'b11100);
    step();
    check_out();
    do_clear();

    // Hazard bubbles: don't-care fields ignored, WB_EN still checked; jumps never checked
    enable = 1'b1;
    step();
    opCode          = OP_ST;
    hazard_detected = 1'b1;
    step();
    opCode          = OP_NOP;
    hazard_detected = 1'b0;
    set_ctrl(EXE_NO_OPERATION, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_out("hz_st", D_L1, 2'd1, 1'b0, 16'd0, 16'd1, 6'd0, 5'd0);
    step();
    check_out();
    opCode          = OP_ADD;
    hazard_detected = 1'b1;
    step();
    opCode          = OP_NOP;
    hazard_detected = 1'b0;
    set_ctrl(EXE_NO_OPERATION, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("hz_wb", D_L1, 2'd1, 1'b1, 16'd1, 16'd2, OP_ADD, 5'b00100);
    step();
    check_out();
    opCode = OP_JMP;
    step();
    opCode = OP_NOP;
    set_ctrl(EXE_SUB, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_out("jmp_skip", D_L1, 2'd1, 1'b1, 16'd1, 16'd2, OP_ADD, 5'b00100);
    step();
    check_out();
    do_clear();

    // STOP_ON_ERR=1: ADDI with Is_Imm=0 halts; STOP_ON_ERR=0 keeps counting
    enable = 1'b1;
    step();
    opCode = OP_ADDI;
    step();
    set_ctrl(EXE_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("stop_first", D_ST, 2'd2, 1'b1, 16'd1, 16'd1, OP_ADDI, 5'b01000);
    step();
    check_out();
    step();
    step();
    expect_out("stop_hold", D_ST, 2'd2, 1'b1, 16'd1, 16'd1, OP_ADDI, 5'b01000);
    expect_out("nostop_cnt", D_L1, 2'd1, 1'b1, 16'd4, 16'd4, OP_ADDI, 5'b01000);
    step();
    check_out();
    check_out();
    clear  = 1'b1;
    enable = 1'b0;
    expect_out("halt_clear", D_ST, 2'd0, 1'b0, 16'd0, 16'd0, 6'd0, 5'd0);
    step();
    check_out();
    clear = 1'b0;
    do_clear();

    // CNT_W=2: five SUB mismatches saturate; clear beats a same-cycle mismatch
    enable = 1'b1;
    step();
    opCode = OP_SUB;
    set_ctrl(EXE_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    expect_out("sat_cnt", D_SAT, 2'd1, 1'b1, 16'd3, 16'd3, OP_SUB, 5'b10000);
    step();
    check_out();
    clear = 1'b1;
    expect_out("sat_clear", D_SAT, 2'd0, 1'b0, 16'd0, 16'd0, 6'd0, 5'd0);
    step();
    check_out();
    clear = 1'b0;
    do_clear();

    // Asynchronous reset with samples in flight (LATENCY=3)
    enable = 1'b1;
    step();
    opCode = OP_ADD;
    set_ctrl(EXE_SUB, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    step();
    step();
    expect_out("pre_rst", D_L3, 2'd1, 1'b1, 16'd1, 16'd1, OP_ADD, 5'b10000);
    step();
    check_out();
    rst = 1'b1;
    expect_out("async_rst", D_L3, 2'd0, 1'b0, 16'd0, 16'd0, 6'd0, 5'd0);
    #1;
    check_out();
    rst = 1'b0;
    step();
    step();
    expect_out("post_rst_quiet", D_L3, 2'd1, 1'b0, 16'd0, 16'd0, 6'd0, 5'd0);
    step();
    check_out();
    step();
    expect_out("post_rst_resume", D_L3, 2'd1, 1'b1, 16'd1, 16'd1, OP_ADD, 5'b10000);
    step();
    check_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cu_ctrl_monitor.md
CU_CTRL_MONITOR -- requirements
Module: cu_ctrl_monitor

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- LATENCY, 1, cycles from opcode sample to control-signal check; range 1..8.
- CNT_W, 16, width of the check and error counters.
- STOP_ON_ERR, 0, 1 = freeze checking after the first mismatch; 0 = keep counting.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- enable, in, 1, arms sampling.
- clear, in, 1, synchronous clear of counters, flags and pipe.
- opCode, in, OP_CODE_LEN, opcode presented to the controller.
- hazard_detected, in, 1, hazard flag presented to the controller.
- EXE_CMD, in, EXE_CMD_LEN, controller output.
- Is_Imm, in, 1, controller output.
- WB_EN, in, 1, controller output.
- MEM_R_EN, in, 1, controller output.
- MEM_W_EN, in, 1, controller output.
- err, out, 1, sticky mismatch flag.
- err_count, out, CNT_W, saturating mismatch count.
- chk_count, out, CNT_W, saturating count of performed checks.
- first_err_op, out, OP_CODE_LEN, opcode of the first mismatch.
- first_err_mask, out, 5, fields that failed at the first mismatch.
- state, out, 2, IDLE=0, RUN=1, HALT=2.

Function
REQ-003 Expected values SHALL come from a fixed table, given as op: EXE_CMD / Is_Imm / WB_EN / MEM_R_EN / MEM_W_EN.
- ADD, SUB, SLA, SRA, AND, OR, NOR, XOR, SLL, SRL: matching EXE_* / 0 / 1 / 0 / 0.
- ADDI: ADD / 1 / 1 / 0 / 0.
- SUBI: SUB / 1 / 1 / 0 / 0.
- LD: ADD / 1 / 1 / 1 / 0.
- ST: ADD / 1 / 0 / 0 / 1.
REQ-004 Any opcode outside REQ-003 (NOP, BEZ, BNE, JMP, undefined) SHALL produce an invalid sample that is never checked.
REQ-005 If hazard_detected=1, the expected values SHALL be EXE_NO_OPERATION, WB_EN=0 and MEM_W_EN=0, with Is_Imm and MEM_R_EN as don't-care; this SHALL apply for any opcode and the sample SHALL be valid.
REQ-006 The sample pipe SHALL hold LATENCY stages of {valid, opcode, expected fields}, shift every cycle, and load valid=1 only in RUN.
REQ-007 The check SHALL occur when the pipe output is valid, the state is not HALT and clear=0.
- It SHALL compare the live controller outputs against the expected fields.
- Mask bits: [4] EXE_CMD, [3] Is_Imm, [2] WB_EN, [1] MEM_R_EN, [0] MEM_W_EN; a don't-care field SHALL never set its bit.
REQ-008 Each check SHALL increment chk_count; a nonzero mask SHALL increment err_count and set err. Both counters SHALL saturate at all-ones.
REQ-009 first_err_op and first_err_mask SHALL load only on a mismatch while err=0, and hold thereafter.
REQ-010 State transitions SHALL be:
- IDLE->RUN when enable=1.
- RUN->IDLE when enable=0.
- RUN->HALT on a mismatch when STOP_ON_ERR=1.
- HALT->IDLE on clear.
- In HALT, enable SHALL be ignored and the counters frozen.
REQ-011 clear SHALL zero the counters, err, the capture registers and all pipe valid bits, and SHALL move the state to IDLE.
- clear SHALL win over a simultaneous check.
REQ-012 In-flight samples SHALL still be checked after RUN->IDLE, and SHALL be discarded on entry to HALT.
REQ-013 The module SHALL be observation-only, with no combinational path from inputs to outputs.

Reset
REQ-014 rst=1 SHALL asynchronously force state=IDLE and all counters, flags, capture registers and pipe valid bits to 0.
REQ-015 Reset asserted mid-check SHALL lose the check; checking SHALL resume only after enable is seen in IDLE.

Structure
REQ-016 The expected-value table, the mask bit positions and the state encoding SHALL live in a shared package, cu_mon_pkg, alongside the existing opcode and EXE defines.
REQ-017 The parametric delay line SHALL be one sub-module, cu_mon_pipe, with parameters (LATENCY, payload width).

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- LATENCY=1, RUN; ADD, hazard=0; next cycle EXE_ADD/0/1/0/0 -> chk_count=1, err=0.
- LATENCY=3, RUN; LD; correct outputs driven 3 cycles later -> chk_count=1, err=0; the same outputs driven at 1 cycle -> err=1, mask=5'b11100.
- RUN; ST with hazard=1; next cycle EXE_NO_OPERATION, WB_EN=0, MEM_W_EN=0, MEM_R_EN=1 -> err=0.
- STOP_ON_ERR=1; ADDI; next cycle Is_Imm=0 -> state=HALT, err_count=1, first_err_op=ADDI, mask=5'b01000; further errors leave err_count=1.
- CNT_W=2; 5 consecutive SUB mismatches -> err_count=3 (saturated); clear on the same cycle as a mismatch -> err_count=0, state=IDLE.
- rst pulse mid-stream with valid samples in flight -> all outputs 0 immediately, no check in the following LATENCY cycles.
